// File: rtl/conv1d_feeder.sv
// Copies len words from system memory into the conv1d sample SRAM over two OBI
// manager ports, one word in flight at a time (read, then write).
module conv1d_feeder #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_W-1:0]     src_addr_i,
   input  logic [ADDR_W-1:0]     dst_addr_i,
   input  logic [LEN_W-1:0]      len_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [LEN_W-1:0]      words_o,
   output logic                  rd_req_o,
   input  logic                  rd_gnt_i,
   output logic [ADDR_W-1:0]     rd_addr_o,
   input  logic                  rd_rvalid_i,
   input  logic [DATA_W-1:0]     rd_rdata_i,
   input  logic                  rd_err_i,
   output logic                  wr_req_o,
   input  logic                  wr_gnt_i,
   output logic [ADDR_W-1:0]     wr_addr_o,
   output logic                  wr_we_o,
   output logic [DATA_W/8-1:0]   wr_be_o,
   output logic [DATA_W-1:0]     wr_wdata_o,
   input  logic                  wr_rvalid_i,
   input  logic                  wr_err_i
);

   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_WR_REQ,
      S_WR_WAIT,
      S_FIN
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   src_q, src_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    words_q, words_d;
   logic [DATA_W-1:0]   buf_q, buf_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                last_word;

   // Compared before incrementing, so the counter can never wrap past len.
   assign last_word = (words_q + LEN_W'(1)) == len_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = (len_i == '0) ? S_FIN : S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            if (rd_gnt_i) begin
               state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (rd_rvalid_i) begin
               state_d = rd_err_i ? S_FIN : S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            if (wr_gnt_i) begin
               state_d = S_WR_WAIT;
            end
         end
         S_WR_WAIT: begin
            if (wr_rvalid_i) begin
               state_d = (wr_err_i || last_word) ? S_FIN : S_RD_REQ;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rd_req_o   = (state_q == S_RD_REQ);
      wr_req_o   = (state_q == S_WR_REQ);
      rd_addr_o  = src_q;
      wr_addr_o  = dst_q;
      wr_wdata_o = buf_q;
      wr_we_o    = 1'b1;
      wr_be_o    = '1;
      busy_o     = busy_q;
      done_o     = done_q;
      err_o      = err_q;
      words_o    = words_q;
   end

   // done and busy are registered so both change together the cycle after FIN.
   always_comb begin
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      words_d = words_q;
      buf_d   = buf_q;
      busy_d  = busy_q;
      err_d   = err_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               src_d   = src_addr_i;
               dst_d   = dst_addr_i;
               len_d   = len_i;
               words_d = '0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_RD_WAIT: begin
            if (rd_rvalid_i) begin
               if (rd_err_i) begin
                  err_d = 1'b1;
               end else begin
                  buf_d = rd_rdata_i;
               end
            end
         end
         S_WR_WAIT: begin
            if (wr_rvalid_i) begin
               if (wr_err_i) begin
                  err_d = 1'b1;
               end else begin
                  words_d = words_q + LEN_W'(1);
                  src_d   = src_q + STRIDE;
                  dst_d   = dst_q + STRIDE;
               end
            end
         end
         S_FIN: begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         words_q <= '0;
         buf_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         words_q <= words_d;
         buf_q   <= buf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_conv1d_feeder.sv
// Bench for conv1d_feeder: OBI memory responders with per-word grant/response
// delays, a queue-based model of the expected bus traffic, and done/busy timing.
module tb_conv1d_feeder;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 16;

   logic            clk;
   logic            rst_i;
   logic            start_i;
   logic [AW-1:0]   src_addr_i;
   logic [AW-1:0]   dst_addr_i;
   logic [LW-1:0]   len_i;
   logic            busy_o;
   logic            done_o;
   logic            err_o;
   logic [LW-1:0]   words_o;
   logic            rd_req_o;
   logic            rd_gnt_i;
   logic [AW-1:0]   rd_addr_o;
   logic            rd_rvalid_i;
   logic [DW-1:0]   rd_rdata_i;
   logic            rd_err_i;
   logic            wr_req_o;
   logic            wr_gnt_i;
   logic [AW-1:0]   wr_addr_o;
   logic            wr_we_o;
   logic [DW/8-1:0] wr_be_o;
   logic [DW-1:0]   wr_wdata_o;
   logic            wr_rvalid_i;
   logic            wr_err_i;

   conv1d_feeder #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o),
      .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_addr_o(rd_addr_o),
      .rd_rvalid_i(rd_rvalid_i), .rd_rdata_i(rd_rdata_i), .rd_err_i(rd_err_i),
      .wr_req_o(wr_req_o), .wr_gnt_i(wr_gnt_i), .wr_addr_o(wr_addr_o),
      .wr_we_o(wr_we_o), .wr_be_o(wr_be_o), .wr_wdata_o(wr_wdata_o),
      .wr_rvalid_i(wr_rvalid_i), .wr_err_i(wr_err_i)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- shared state ----------------
   int check_cnt = 0;
   int err_cnt   = 0;

   logic [31:0] src_mem [logic [31:0]];
   logic [31:0] dst_mem [logic [31:0]];
   logic [31:0] exp_rd_q[$];
   logic [31:0] exp_wa_q[$];
   logic [31:0] exp_wd_q[$];

   int gd_r [64];
   int rv_r [64];
   int gd_w [64];
   int rv_w [64];
   int rd_idx, wr_idx;
   int err_rd_idx = -1;
   int err_wr_idx = -1;
   bit spurious = 1'b0;
   int done_seen;
   logic [31:0] rd_seen_addr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      check_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] src_data(input logic [31:0] a);
      if (src_mem.exists(a)) return src_mem[a];
      return {a[15:0] ^ 16'h5a3c, a[31:16]};
   endfunction

   task automatic gen_delays(input int max_gd_r, input int max_gd_w, input int max_rv);
      for (int i = 0; i < 64; i++) begin
         gd_r[i] = $urandom_range(0, max_gd_r);
         gd_w[i] = $urandom_range(0, max_gd_w);
         rv_r[i] = $urandom_range(1, max_rv);
         rv_w[i] = $urandom_range(1, max_rv);
      end
   endtask

   // ---------------- read-port responder ----------------
   initial begin
      bit          pend;
      int          wait_n, rv_n;
      logic [31:0] r_data;
      bit          r_err;
      pend = 0; wait_n = 0; rv_n = 0; r_data = '0; r_err = 0;
      rd_gnt_i = 0; rd_rvalid_i = 0; rd_rdata_i = '0; rd_err_i = 0;
      forever begin
         @(negedge clk);
         rd_gnt_i = 0; rd_rvalid_i = 0; rd_err_i = 0; rd_rdata_i = $urandom;
         if (rst_i) begin
            pend = 0; wait_n = 0;
         end else if (pend) begin
            rv_n--;
            if (rv_n == 0) begin
               rd_rvalid_i = 1; rd_rdata_i = r_data; rd_err_i = r_err; pend = 0;
            end
         end else if (rd_req_o) begin
            if (wait_n < gd_r[rd_idx]) begin
               wait_n++;
               if (spurious && $urandom_range(0, 1) == 1) begin
                  rd_rvalid_i = 1; rd_err_i = 1'($urandom_range(0, 1));
               end
            end else begin
               rd_gnt_i = 1;
               r_data = src_data(rd_addr_o);
               r_err = (err_rd_idx == rd_idx);
               rv_n = rv_r[rd_idx];
               pend = 1; wait_n = 0;
               rd_idx++;
            end
         end else if (spurious && $urandom_range(0, 3) == 0) begin
            rd_rvalid_i = 1; rd_err_i = 1'($urandom_range(0, 1));
         end
      end
   end

   // ---------------- write-port responder ----------------
   initial begin
      bit pend;
      int wait_n, rv_n;
      bit w_err;
      pend = 0; wait_n = 0; rv_n = 0; w_err = 0;
      wr_gnt_i = 0; wr_rvalid_i = 0; wr_err_i = 0;
      forever begin
         @(negedge clk);
         wr_gnt_i = 0; wr_rvalid_i = 0; wr_err_i = 0;
         if (rst_i) begin
            pend = 0; wait_n = 0;
         end else if (pend) begin
            rv_n--;
            if (rv_n == 0) begin
               wr_rvalid_i = 1; wr_err_i = w_err; pend = 0;
            end
         end else if (wr_req_o) begin
            if (wait_n < gd_w[wr_idx]) begin
               wait_n++;
               if (spurious && $urandom_range(0, 1) == 1) begin
                  wr_rvalid_i = 1; wr_err_i = 1'($urandom_range(0, 1));
               end
            end else begin
               wr_gnt_i = 1;
               dst_mem[wr_addr_o] = wr_wdata_o;
               w_err = (err_wr_idx == wr_idx);
               rv_n = rv_w[wr_idx];
               pend = 1; wait_n = 0;
               wr_idx++;
            end
         end else if (spurious && $urandom_range(0, 3) == 0) begin
            wr_rvalid_i = 1; wr_err_i = 1'($urandom_range(0, 1));
         end
      end
   end

   // ---------------- scoreboard: bus traffic against the model queues ----------------
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst_i) begin
            chk("req_exclusive", {63'd0, rd_req_o & wr_req_o}, 64'd0);
            if (rd_req_o) begin
               if (exp_rd_q.size() == 0) begin
                  chk("rd_req_unexpected", {63'd0, rd_req_o}, 64'd0);
               end else begin
                  chk("rd_addr", {32'd0, rd_addr_o}, {32'd0, exp_rd_q[0]});
                  if (rd_gnt_i) begin
                     rd_seen_addr = rd_addr_o;
                     void'(exp_rd_q.pop_front());
                  end
               end
            end
            if (wr_req_o) begin
               if (exp_wa_q.size() == 0) begin
                  chk("wr_req_unexpected", {63'd0, wr_req_o}, 64'd0);
               end else begin
                  chk("wr_addr", {32'd0, wr_addr_o}, {32'd0, exp_wa_q[0]});
                  chk("wr_wdata", {32'd0, wr_wdata_o}, {32'd0, exp_wd_q[0]});
                  chk("wr_we_be", {59'd0, wr_we_o, wr_be_o}, 64'h1F);
                  if (wr_gnt_i) begin
                     void'(exp_wa_q.pop_front());
                     void'(exp_wd_q.pop_front());
                  end
               end
            end
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
      chk({tag, "_done"}, {63'd0, done_o}, 64'd0);
      chk({tag, "_err"}, {63'd0, err_o}, 64'd0);
      chk({tag, "_words"}, {48'd0, words_o}, 64'd0);
      chk({tag, "_reqs"}, {62'd0, rd_req_o, wr_req_o}, 64'd0);
      chk({tag, "_addrs"}, {rd_addr_o, wr_addr_o}, 64'd0);
      chk({tag, "_wdata"}, {32'd0, wr_wdata_o}, 64'd0);
      chk({tag, "_we_be"}, {59'd0, wr_we_o, wr_be_o}, 64'h1F);
   endtask

   // ---------------- transfer driver with model ----------------
   // restart_cyc: cycle to re-pulse start (0 none, -1 the FIN cycle).
   // rst_cyc: cycle at which reset is asserted mid-transfer (0 none).
   task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input int restart_cyc, input int rst_cyc);
      int exp_done, exp_words, rc;
      bit exp_err;
      exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
      exp_done = 2; exp_words = 0; exp_err = 0;
      for (int i = 0; i < len; i++) begin
         logic [31:0] sa, da;
         sa = src + 32'(4 * i);
         da = dst + 32'(4 * i);
         exp_rd_q.push_back(sa);
         exp_done += 1 + gd_r[i] + rv_r[i];
         if (i == err_rd_idx) begin exp_err = 1; break; end
         exp_wa_q.push_back(da);
         exp_wd_q.push_back(src_data(sa));
         exp_done += 1 + gd_w[i] + rv_w[i];
         if (i == err_wr_idx) begin exp_err = 1; break; end
         exp_words++;
      end
      rc = (restart_cyc < 0) ? exp_done - 1 : restart_cyc;
      done_seen = -1;
      rd_idx = 0; wr_idx = 0;

      @(negedge clk);
      start_i = 1; src_addr_i = src; dst_addr_i = dst; len_i = LW'(len);
      for (int c = 1; c <= exp_done; c++) begin
         @(negedge clk);
         if (c == 1) start_i = 0;
         if (c == rc) begin
            start_i = 1; src_addr_i = ~src; dst_addr_i = ~dst; len_i = LW'(len + 3);
         end else if (c == rc + 1) begin
            start_i = 0; src_addr_i = src; dst_addr_i = dst; len_i = LW'(len);
         end
         if (c == 1) begin
            chk("start_words_clear", {48'd0, words_o}, 64'd0);
            chk("start_err_clear", {63'd0, err_o}, 64'd0);
         end
         chk("busy", {63'd0, busy_o}, {63'd0, c < exp_done});
         chk("done", {63'd0, done_o}, {63'd0, c == exp_done});
         if (done_o && done_seen < 0) done_seen = c;
         if (rst_cyc > 0 && c == rst_cyc) begin
            #2;
            rst_i = 1;
            #1;
            chk_reset_outputs("midrst");
            repeat (2) begin
               @(negedge clk);
               chk("midrst_no_done", {63'd0, done_o}, 64'd0);
            end
            rst_i = 0;
            repeat (4) begin
               @(negedge clk);
               chk("postrst_idle", {62'd0, done_o, busy_o}, 64'd0);
            end
            exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
            return;
         end
      end
      start_i = 0;
      chk("end_words", {48'd0, words_o}, 64'(exp_words));
      chk("end_err", {63'd0, err_o}, {63'd0, exp_err});
      chk("end_queues_empty", 64'(exp_rd_q.size() + exp_wa_q.size()), 64'd0);
      @(negedge clk);
      chk("after_done_idle", {62'd0, done_o, busy_o}, 64'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [31:0] s, d;
      int n, r;
      rst_i = 1; start_i = 0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_i = 0;
      @(negedge clk);
      chk_reset_outputs("post_reset");

      // Best-case 4-word copy
      for (int i = 0; i < 4; i++) src_mem[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
      gen_delays(0, 0, 1);
      run_xfer(32'h1000, 32'h3000_0000, 4, 0, 0);
      chk("t1_done_cycle", 64'(done_seen), 64'd18);
      chk("t1_words_lit", {48'd0, words_o}, 64'd4);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a;
         a = 32'h3000_0000 + 32'(4 * i);
         chk("t1_dst_mem", {32'd0, dst_mem[a]}, 64'(32'hA0 + i));
      end

      // Same copy with rd grant 3 late and wr grant 2 late
      dst_mem.delete();
      for (int i = 0; i < 64; i++) begin
         gd_r[i] = 3; gd_w[i] = 2; rv_r[i] = 1; rv_w[i] = 1;
      end
      run_xfer(32'h1000, 32'h3000_0000, 4, 0, 0);
      chk("t2_done_cycle", 64'(done_seen), 64'd38);
      chk("t2_dst_last", {32'd0, dst_mem[32'h3000_000C]}, 64'hA3);

      // Zero length
      gen_delays(0, 0, 1);
      run_xfer(32'h2000, 32'h3000_0100, 0, 0, 0);
      chk("t3_done_cycle", 64'(done_seen), 64'd2);

      // Read error on the second of three reads
      err_rd_idx = 1;
      run_xfer(32'h1000, 32'h3000_0200, 3, 0, 0);
      chk("t4_err_lit", {63'd0, err_o}, 64'd1);
      chk("t4_words_lit", {48'd0, words_o}, 64'd1);
      err_rd_idx = -1;

      // Write error on the third write, then a clean run clears err
      err_wr_idx = 2;
      gen_delays(1, 1, 2);
      run_xfer(32'h4000, 32'h3000_0300, 5, 0, 0);
      chk("t5_words_lit", {48'd0, words_o}, 64'd2);
      err_wr_idx = -1;

      // Start re-pulsed mid-transfer and in FIN
      gen_delays(0, 0, 1);
      run_xfer(32'h1000, 32'h3000_0400, 4, 3, 0);
      run_xfer(32'h1000, 32'h3000_0500, 2, -1, 0);
      run_xfer(32'h1000, 32'h3000_0600, 0, -1, 0);

      // Source address wrap, reset during WR_WAIT of the second word
      gen_delays(0, 0, 1);
      rv_w[1] = 3;
      run_xfer(32'hFFFF_FFFC, 32'h3000_0700, 2, 0, 8);
      chk("t7_wrap_addr", {32'd0, rd_seen_addr}, 64'd0);

      // Randomised transfers with spurious responses
      spurious = 1;
      for (int it = 0; it < 30; it++) begin
         n = $urandom_range(0, 8);
         s = $urandom & 32'hFFFF_FFFC;
         d = $urandom & 32'hFFFF_FFFC;
         r = $urandom_range(0, 3);
         err_rd_idx = -1; err_wr_idx = -1;
         if (n > 0 && r == 0) err_rd_idx = $urandom_range(0, n - 1);
         if (n > 0 && r == 1) err_wr_idx = $urandom_range(0, n - 1);
         gen_delays(3, 3, 3);
         run_xfer(s, d, n, (it % 5 == 0) ? 3 : 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/conv1d_feeder.md
Name: conv1d_feeder

Overview:
- Upstream stage of the conv1d accelerator.
- Copies a block of input samples from system memory into the conv1d sample SRAM, one word at a time.
- Has two OBI manager ports: a read port towards system memory and a write port towards the conv1d OBI subordinate.
- Started by a pulse from the control logic; signals completion with a one-cycle done pulse and a sticky-until-next-start error flag.

Parameters:
- ADDR_W, 32, address width of both OBI ports.
- DATA_W, 32, data width of both OBI ports; address stride is DATA_W/8.
- LEN_W, 16, width of the word-count field.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  one-cycle start pulse
- src_addr_i  in  ADDR_W  source base byte address, word aligned
- dst_addr_i  in  ADDR_W  destination base byte address in conv1d SRAM, word aligned
- len_i  in  LEN_W  number of words to copy
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse when a transfer ends (normally or on error)
- err_o  out  1  last transfer aborted on bus error
- words_o  out  LEN_W  words written so far in the current/last transfer
- rd_req_o  out  1  read-port OBI request
- rd_gnt_i  in  1  read-port OBI grant
- rd_addr_o  out  ADDR_W  read address
- rd_rvalid_i  in  1  read response valid
- rd_rdata_i  in  DATA_W  read data
- rd_err_i  in  1  read response error
- wr_req_o  out  1  write-port OBI request
- wr_gnt_i  in  1  write-port OBI grant
- wr_addr_o  out  ADDR_W  write address
- wr_we_o  out  1  write enable, constant 1
- wr_be_o  out  DATA_W/8  byte enables, all ones
- wr_wdata_o  out  DATA_W  write data
- wr_rvalid_i  in  1  write response valid
- wr_err_i  in  1  write response error

Behaviour:
- Reset values (asynchronous on rst_i): every output is 0 except wr_we_o (1) and wr_be_o (all ones). Internal address, count and data registers clear; FSM goes to IDLE.
- Reset mid-transfer aborts immediately; requests drop the same cycle; no done pulse is issued.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE:
  - On start_i, latch src, dst and len; clear words_o and err_o; set busy_o.
  - Go to FIN if len_i==0, else go to RD_REQ.
  - start_i while busy_o=1 is ignored, with no side effects.
- RD_REQ: rd_req_o=1 and rd_addr_o=current source address, both held stable until rd_gnt_i. On grant, go to RD_WAIT.
- RD_WAIT:
  - Responses are accepted from the cycle after the grant onward, with no timeout.
  - On rd_rvalid_i with rd_err_i=1: set err_o, go to FIN.
  - Otherwise capture rd_rdata_i into the buffer register and go to WR_REQ.
- WR_REQ: wr_req_o=1 with wr_addr_o=current destination address and wr_wdata_o=buffer, all held stable until wr_gnt_i. On grant, go to WR_WAIT.
- WR_WAIT:
  - On wr_rvalid_i with wr_err_i=1: set err_o, go to FIN.
  - Otherwise increment words_o and advance both addresses by DATA_W/8.
  - If words_o+1==len, go to FIN, else go to RD_REQ.
- FIN: done_o=1 for exactly one cycle; busy_o drops the same cycle; go to IDLE. A start_i in FIN is ignored.
- At most one outstanding transaction in total; the read and write ports are never requested in the same cycle.
- Address arithmetic is modulo 2^ADDR_W (wrap, no error). The length counter never overflows because the count is compared with len before incrementing.
- rvalid arriving in RD_REQ/WR_REQ or in IDLE (a spurious response) is ignored.
- Best case per word is 4 cycles (req/gnt same cycle, rvalid the next cycle, on each port). A transfer of N words takes 4N+2 cycles from start_i to done_o.
- After an error, words_o holds the number of words completed successfully before the failing access.

Test Plan:
- src=0x1000, dst=0x3000_0000, len=4, memory 0xA0..0xA3, gnt same cycle, rvalid next cycle -> dst words 0..3 = 0xA0..0xA3; done_o at cycle 18 after start; words_o=4; err_o=0.
- Same transfer with rd_gnt_i delayed 3 cycles and wr_gnt_i delayed 2 cycles -> rd_addr_o/wr_addr_o/wr_wdata_o stable while the request waits; data correct; done after 4*4+2+20 cycles.
- len=0 -> no rd_req_o/wr_req_o ever asserted; done_o pulses 2 cycles after start; words_o=0.
- len=3, rd_err_i on the 2nd read -> 1 word written; err_o=1; words_o=1; done_o pulses; no 2nd write issued.
- start_i re-pulsed mid-transfer with other addresses -> ignored; original transfer completes unchanged.
- src=0xFFFF_FFFC, len=2 -> reads go to 0xFFFF_FFFC then 0x0000_0000; rst_i asserted during WR_WAIT of the 2nd word -> all outputs 0 immediately; no done_o.
